// File: rtl/pc_unit.sv
// Program counter unit: sequential fetch, branch redirect, stall and halt.
// pc, flush and halted are all registered. pc_plus4 is the only
// combinational output, and it depends on pc alone.
module pc_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,       // synchronous, active-low
  input  logic        stall,
  input  logic        halt,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic        br_uncond,
  input  logic        br_reg,
  input  logic [63:0] br_pc,
  input  logic [25:0] br_imm26,
  input  logic [18:0] br_imm19,
  input  logic [63:0] reg_target,
  output logic [63:0] pc,
  output logic [63:0] pc_plus4,
  output logic        flush,
  output logic        halted
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        flush_q, flush_d;

  logic        redirect;
  logic [63:0] offset;
  logic [63:0] target;

  // Branch target: sign-extended word offset from the branch address, or a register.
  always_comb begin
    redirect = br_valid & (br_uncond | br_taken);
    offset   = br_uncond ? {{38{br_imm26[25]}}, br_imm26}
                         : {{45{br_imm19[18]}}, br_imm19};
    target   = br_reg ? reg_target : br_pc + (offset << 2);
  end

  // Next state: redirect beats halt, halt beats stall, stall beats pc + 4.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (redirect) begin
          pc_d    = target;
          flush_d = 1'b1;
        end else if (halt) begin
          state_d = HALTED;
        end else if (!stall) begin
          pc_d = pc_q + 64'd4;
        end
      end
      HALTED: begin
        // Frozen until reset; every other input is ignored.
      end
      default: state_d = RUN;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments, so every flop samples
    // the values from before the edge no matter how the blocks are ordered.
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
    end
  end

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 64'd4;
  assign flush    = flush_q;
  assign halted   = (state_q == HALTED);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit. A behavioural model tracks the expected
// pc, flush and halted values. One process compares the DUT against the
// model on every falling edge, and directed scenarios pin the model to
// hand-computed values. A randomized phase follows the directed scenarios.
module tb_pc_unit;

  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset, stall, halt;
  logic        br_valid, br_taken, br_uncond, br_reg;
  logic [63:0] br_pc, reg_target;
  logic [25:0] br_imm26;
  logic [18:0] br_imm19;
  logic [63:0] pc, pc_plus4;
  logic        flush, halted;

  int n_vec  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  logic [63:0] exp_pc;
  logic        exp_flush, exp_halted;

  pc_unit #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .halt       (halt),
    .br_valid   (br_valid),
    .br_taken   (br_taken),
    .br_uncond  (br_uncond),
    .br_reg     (br_reg),
    .br_pc      (br_pc),
    .br_imm26   (br_imm26),
    .br_imm19   (br_imm19),
    .reg_target (reg_target),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .flush      (flush),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Branch target computed with signed integer arithmetic, wrapping modulo 2^64.
  function automatic logic [63:0] branch_target();
    longint off;
    off = br_uncond ? longint'($signed(br_imm26)) : longint'($signed(br_imm19));
    if (br_reg) return reg_target;
    return br_pc + 64'(off * 4);
  endfunction

  // Behavioural reference model, advanced on every rising edge.
  always @(posedge clk) begin
    if (!reset) begin
      exp_pc     <= RESET_PC;
      exp_flush  <= 1'b0;
      exp_halted <= 1'b0;
    end else if (exp_halted) begin
      exp_flush  <= 1'b0;
    end else if (br_valid && (br_uncond || br_taken)) begin
      exp_pc     <= branch_target();
      exp_flush  <= 1'b1;
    end else begin
      exp_flush  <= 1'b0;
      if (halt)        exp_halted <= 1'b1;
      else if (!stall) exp_pc     <= exp_pc + 64'd4;
    end
  end

  // Compare process: DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("pc",       pc,       exp_pc);
      check("pc_plus4", pc_plus4, exp_pc + 64'd4);
      check("flush",    64'(flush),  64'(exp_flush));
      check("halted",   64'(halted), 64'(exp_halted));
    end
  end

  // Deassert all branch and control inputs except reset.
  task automatic idle();
    stall = 0; halt = 0;
    br_valid = 0; br_taken = 0; br_uncond = 0; br_reg = 0;
    br_pc = '0; reg_target = '0; br_imm26 = '0; br_imm19 = '0;
  endtask

  // Apply the current inputs across one rising edge and return at the next falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  // Check pc, flush and halted against hand-computed values.
  task automatic pin(input string name, input logic [63:0] p, input logic f, input logic h);
    check({name, ".pc"},     pc,          p);
    check({name, ".flush"},  64'(flush),  64'(f));
    check({name, ".halted"}, 64'(halted), 64'(h));
  endtask

  initial begin
    reset = 0;
    idle();
    @(negedge clk);
    check_en = 1'b1;
    cyc();
    pin("reset", 64'h0, 0, 0);

    // Free-running sequential fetch.
    reset = 1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      pin("seq", 64'(i * 4), 0, 0);
    end

    // Taken conditional branch with a negative offset, then the same branch not taken.
    br_valid = 1; br_taken = 1; br_pc = 64'h100; br_imm19 = 19'h7FFFE;
    cyc(); pin("cond_taken", 64'hF8, 1, 0);
    br_taken = 0;
    cyc(); pin("cond_not_taken", 64'hFC, 0, 0);

    // Unconditional immediate branch, then a register branch.
    idle(); br_valid = 1; br_uncond = 1; br_pc = 64'h40; br_imm26 = 26'd3;
    cyc(); pin("uncond", 64'h4C, 1, 0);
    br_reg = 1; reg_target = 64'hDEAD_BEE0;
    cyc(); pin("reg_br", 64'hDEAD_BEE0, 1, 0);

    // Stall holds pc; a taken branch still redirects while stalled.
    idle(); stall = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(); pin("stall", 64'hDEAD_BEE0, 0, 0);
    end
    br_valid = 1; br_uncond = 1; br_pc = 64'h1000; br_imm26 = 26'h3FF_FFFF;
    cyc(); pin("stall_redirect", 64'hFFC, 1, 0);

    // Back-to-back redirects give consecutive flush cycles.
    idle(); br_valid = 1; br_uncond = 1; br_reg = 1; reg_target = 64'h200;
    cyc(); pin("b2b_1", 64'h200, 1, 0);
    reg_target = 64'h300;
    cyc(); pin("b2b_2", 64'h300, 1, 0);

    // Halt and redirect in the same cycle: the redirect wins.
    halt = 1; reg_target = 64'h400;
    cyc(); pin("halt_redirect", 64'h400, 1, 0);

    // Halt freezes pc; later branches and stalls are ignored.
    idle(); halt = 1;
    cyc(); pin("halt", 64'h400, 0, 1);
    halt = 0; stall = 1; br_valid = 1; br_uncond = 1; br_reg = 1; reg_target = 64'h800;
    for (int i = 0; i < 3; i++) begin
      cyc(); pin("halted_ignore", 64'h400, 0, 1);
    end

    // Reset together with a taken branch while halted, and then while running.
    reset = 0;
    cyc(); pin("reset_halted", RESET_PC, 0, 0);
    idle(); reset = 1;
    cyc(); pin("reset_release", RESET_PC + 64'd4, 0, 0);
    reset = 0; br_valid = 1; br_uncond = 1; br_reg = 1; reg_target = 64'h900;
    cyc(); pin("reset_run", RESET_PC, 0, 0);

    // pc wraps modulo 2^64.
    reset = 1; reg_target = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc(); pin("wrap_set", 64'hFFFF_FFFF_FFFF_FFFC, 1, 0);
    check("wrap_plus4", pc_plus4, 64'h0);
    idle();
    cyc(); pin("wrap", 64'h0, 0, 0);

    // Randomized stimulus, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 79) != 0);
      halt       = ($urandom_range(0, 39) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      br_valid   = ($urandom_range(0, 2) == 0);
      br_taken   = 1'($urandom);
      br_uncond  = 1'($urandom);
      br_reg     = br_uncond & ($urandom_range(0, 2) == 0);
      br_pc      = {$urandom, $urandom};
      reg_target = {$urandom, $urandom};
      br_imm26   = 26'($urandom);
      br_imm19   = 19'($urandom);
      cyc();
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
